// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the repeated-addition multiplier sequencer.
package mult_seq_ctrl_pkg;

  // Default operand width; the product is twice this wide.
  localparam int unsigned MULT_N = 8;

  // Sequencer states, encoded as in the original shared header.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_e;

endpackage : mult_seq_ctrl_pkg

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the repeated-addition multiplier: handshakes an operand pair,
// drives the external down-counter and accumulates the larger operand once
// per count into a 2N-bit product register.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int unsigned N = MULT_N
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           abort,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic [2*N-1:0] product,
  output logic           cnt_load,
  output logic           cnt_dec,
  output logic [N-1:0]   cnt_data,
  input  logic [N-1:0]   cnt_count
);

  localparam logic [N-1:0] CNT_ONE = N'(1);

  mult_state_e    state_q,    state_d;
  logic [N-1:0]   mcand_q,    mcand_d;
  logic [N-1:0]   cnt_data_q, cnt_data_d;
  logic [2*N-1:0] product_q,  product_d;
  logic           aborted_q,  aborted_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mcand_q    <= '0;
      cnt_data_q <= '0;
      product_q  <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      cnt_data_q <= cnt_data_d;
      product_q  <= product_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next-state, datapath update and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    cnt_data_d = cnt_data_q;
    product_d  = product_q;
    aborted_d  = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          // Smaller operand drives the count; on a tie the count comes from b.
          mcand_d    = (a < b) ? b : a;
          cnt_data_d = (a < b) ? a : b;
          product_d  = '0;
          state_d    = (a == '0 || b == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy     = 1'b1;
        cnt_load = 1'b1;
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          product_d = '0;
        end else begin
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        busy = 1'b1;
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          product_d = '0;
        end else begin
          if (cnt_count != '0) begin
            product_d = product_q + {{N{1'b0}}, mcand_q};
            cnt_dec   = 1'b1;
          end
          // A count of 1 is the final add; 0 on entry is only defensive.
          if (cnt_count <= CNT_ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign aborted  = aborted_q;
  assign product  = product_q;
  assign cnt_data = cnt_data_q;

endmodule : mult_seq_ctrl

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl together with an 8-bit loadable
// down-counter whose active-high reset is tied to ~reset_n.
module tb_mult_seq_ctrl;

  localparam int unsigned N = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           abort = 1'b0;
  logic           ready, busy, done, aborted;
  logic [2*N-1:0] product;
  logic           cnt_load, cnt_dec;
  logic [N-1:0]   cnt_data;
  logic [N-1:0]   cnt_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .product   (product),
    .cnt_load  (cnt_load),
    .cnt_dec   (cnt_dec),
    .cnt_data  (cnt_data),
    .cnt_count (cnt_count)
  );

  // External down-counter.
  logic cnt_rst;
  assign cnt_rst = ~reset_n;
  always_ff @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst)       cnt_count <= '0;
    else if (cnt_load) cnt_count <= cnt_data;
    else if (cnt_dec)  cnt_count <= cnt_count - 8'd1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operation-timeline model: an accepted op is described by the elapsed
  // cycle count k since acceptance; all outputs follow from k, a and b.
  bit     m_active = 0;
  int     m_k = 0;
  longint m_a = 0, m_b = 0, m_min = 0, m_max = 0;
  bit     m_zero = 0;
  longint m_prod = 0;
  longint m_cdata = 0;
  bit     m_aborted = 0;

  initial begin : compare
    int dk;
    longint e_prod;
    bit e_ready, e_busy, e_done, e_load, e_dec;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_active = 0; m_prod = 0; m_cdata = 0; m_aborted = 0;
      end
      if (m_active) begin
        dk      = m_zero ? 1 : int'(m_min) + 2;
        e_ready = 0;
        e_busy  = (m_k < dk);
        e_done  = (m_k == dk);
        e_load  = (m_k == 1) && !m_zero;
        e_dec   = (m_k >= 2) && (m_k < dk) && !abort;
        if (m_k < 2)       e_prod = 0;
        else if (m_k < dk) e_prod = m_max * longint'(m_k - 2);
        else               e_prod = m_a * m_b;
      end else begin
        e_ready = 1; e_busy = 0; e_done = 0; e_load = 0; e_dec = 0;
        e_prod  = m_prod;
      end
      chk("ready",    ready,    e_ready);
      chk("busy",     busy,     e_busy);
      chk("done",     done,     e_done);
      chk("aborted",  aborted,  m_active ? 0 : m_aborted);
      chk("cnt_load", cnt_load, e_load);
      chk("cnt_dec",  cnt_dec,  e_dec);
      chk("cnt_data", cnt_data, m_cdata);
      chk("product",  product,  e_prod);

      @(posedge clk);
      if (reset_n) begin
        if (m_active) begin
          dk = m_zero ? 1 : int'(m_min) + 2;
          m_aborted = 0;
          if (m_k < dk && abort) begin
            m_active = 0; m_aborted = 1; m_prod = 0;
          end else if (m_k == dk) begin
            m_active = 0; m_prod = m_a * m_b;
          end else begin
            m_k++;
          end
        end else begin
          m_aborted = 0;
          if (start) begin
            m_active = 1; m_k = 1;
            m_a = a; m_b = b;
            m_min = (a < b) ? a : b;
            m_max = (a < b) ? b : a;
            m_zero = (a == 0) || (b == 0);
            m_cdata = m_min; m_prod = 0;
          end
        end
      end
    end
  end

  // Runs one operation; n counts cycles after the accept cycle.
  task automatic run_op(input int av, input int bv, input int abort_at, input int restart_at,
                        output int lat, output longint prod, output bit saw_load,
                        output bit ab, output bit rdy_at_end);
    int n;
    lat = -1; prod = -1; saw_load = 0; ab = 0; rdy_at_end = 0;
    @(posedge clk); #1;
    start = 1; a = N'(av); b = N'(bv);
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (n < 600) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      n++;
      abort = (n == abort_at);
      if (n == restart_at) begin
        start = 1; a = 8'd100; b = 8'd100;
      end else begin
        start = 0;
      end
      @(negedge clk);
      if (cnt_load) saw_load = 1;
      if (done || aborted) begin
        lat = n; prod = product; ab = aborted; rdy_at_end = ready;
        break;
      end
    end
    abort = 0; start = 0;
    if (lat < 0) chk("op_timeout", n, -1);
  endtask

  initial begin : stim
    int lat;
    longint prod;
    bit sl, ab, rdy;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",   ready,   1);
    chk("reset_busy",    busy,    0);
    chk("reset_product", product, 0);
    @(posedge clk); #1 reset_n = 1;

    run_op(6, 3, 0, 0, lat, prod, sl, ab, rdy);
    chk("6x3_lat", lat, 5);
    chk("6x3_prod", prod, 18);

    run_op(0, 200, 0, 0, lat, prod, sl, ab, rdy);
    chk("0x200_lat", lat, 1);
    chk("0x200_prod", prod, 0);
    chk("0x200_noload", sl, 0);

    run_op(255, 255, 0, 0, lat, prod, sl, ab, rdy);
    chk("255x255_lat", lat, 257);
    chk("255x255_prod", prod, 65025);

    run_op(9, 7, 3, 0, lat, prod, sl, ab, rdy);
    chk("abort_seen", ab, 1);
    chk("abort_lat", lat, 4);
    chk("abort_prod", prod, 0);
    chk("abort_ready", rdy, 1);

    run_op(6, 3, 0, 2, lat, prod, sl, ab, rdy);
    chk("restart_ignored_lat", lat, 5);
    chk("restart_ignored_prod", prod, 18);

    run_op(4, 4, 0, 0, lat, prod, sl, ab, rdy);
    chk("4x4_lat", lat, 6);
    chk("4x4_prod", prod, 16);

    run_op(3, 6, 0, 0, lat, prod, sl, ab, rdy);
    chk("3x6_lat", lat, 5);
    chk("3x6_prod", prod, 18);

    // Reset in the middle of an ADD sequence.
    @(posedge clk); #1;
    start = 1; a = 8'd200; b = 8'd50;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #1 reset_n = 0;
    @(negedge clk);
    chk("midreset_ready",   ready,   1);
    chk("midreset_busy",    busy,    0);
    chk("midreset_product", product, 0);
    @(posedge clk); #1 reset_n = 1;

    run_op(2, 5, 0, 0, lat, prod, sl, ab, rdy);
    chk("2x5_lat", lat, 4);
    chk("2x5_prod", prod, 10);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mult_seq_ctrl
